// File: rtl/match_run_tracker.sv
// match_run_tracker: consecutive-match run tracker for a comparator stream.
// Counts matching samples, tracks the current and longest run of matches,
// and locks once a run reaches THRESH, pulsing run_event on lock entry.
// Optional feature: define MATCH_RUN_TRACKER_MISMATCH_CNT_EN to add the
// mismatch_cnt output counting accepted z=0 samples.
module match_run_tracker #(
  parameter int CNT_W  = 8,
  parameter int RUN_W  = 4,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             z,
  input  logic             clear,
  output logic             in_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic             locked,
  output logic             run_event
`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
  , output logic [CNT_W-1:0] mismatch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [RUN_W-1:0] THRESH_V = RUN_W'(THRESH);

  state_t           state, state_next;
  logic             accept;
  logic [RUN_W-1:0] run_len_next;
  logic [RUN_W-1:0] max_run_next;
  logic [CNT_W-1:0] match_cnt_next;
  logic             locked_next;
  logic             run_event_next;
`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mismatch_cnt_next;
`endif

  // clear blocks acceptance, so a sample offered alongside clear is dropped.
  assign in_ready = ~clear;
  assign accept   = in_valid & in_ready;

  // Next-state and next-statistics computation; clear outranks any sample.
  always_comb begin
    state_next     = state;
    run_len_next   = run_len;
    max_run_next   = max_run;
    match_cnt_next = match_cnt;
    run_event_next = 1'b0;
`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
    mismatch_cnt_next = mismatch_cnt;
`endif

    if (clear) begin
      state_next     = IDLE;
      run_len_next   = '0;
      max_run_next   = '0;
      match_cnt_next = '0;
`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
      mismatch_cnt_next = '0;
`endif
    end else if (accept) begin
      if (z) begin
        // Both counters saturate rather than wrap.
        run_len_next   = (run_len == RUN_MAX) ? run_len : run_len + 1'b1;
        match_cnt_next = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;
        case (state)
          IDLE:    state_next = (THRESH == 1) ? LOCK : RUN;
          RUN:     state_next = (run_len_next >= THRESH_V) ? LOCK : RUN;
          LOCK:    state_next = LOCK;
          default: state_next = IDLE;
        endcase
        // Longest run follows the new run length in the same cycle.
        max_run_next   = (run_len_next > max_run) ? run_len_next : max_run;
        // Fire only on the transition into LOCK, never while staying there.
        run_event_next = (state != LOCK) && (state_next == LOCK);
      end else begin
        state_next   = IDLE;
        run_len_next = '0;
`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
        mismatch_cnt_next = (mismatch_cnt == CNT_MAX) ? mismatch_cnt
                                                      : mismatch_cnt + 1'b1;
`endif
      end
    end
  end

  // locked is registered alongside the state so it is a clean flop output.
  always_comb begin
    locked_next = (state_next == LOCK);
  end

  // State and statistics registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_len   <= '0;
      max_run   <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      run_event <= 1'b0;
    end else begin
      state     <= state_next;
      run_len   <= run_len_next;
      max_run   <= max_run_next;
      match_cnt <= match_cnt_next;
      locked    <= locked_next;
      run_event <= run_event_next;
    end
  end

`ifdef MATCH_RUN_TRACKER_MISMATCH_CNT_EN
  // Mismatch counter register, reset and cleared like match_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else begin
      mismatch_cnt <= mismatch_cnt_next;
    end
  end
`endif

endmodule

// File: doc/match_run_tracker.md
MATCH_RUN_TRACKER -- requirements
Module: match_run_tracker

Interface
REQ-001 Parameter CNT_W, default 8: width of the match and mismatch counters.
REQ-002 Parameter RUN_W, default 4: width of the run-length registers.
REQ-003 Parameter THRESH, default 3: run length that triggers lock; legal range 1 to 2^RUN_W-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  comparator result z is valid this cycle.
REQ-007 z  input  1  equality result from the 2-bit comparator (1 = match).
REQ-008 clear  input  1  synchronous clear of all statistics.
REQ-009 in_ready  output  1  block can accept a sample this cycle.
REQ-010 match_cnt  output  CNT_W  total accepted samples with z=1.
REQ-011 run_len  output  RUN_W  current length of the consecutive-match run.
REQ-012 max_run  output  RUN_W  longest run since reset or clear.
REQ-013 locked  output  1  high while the FSM is in LOCK.
REQ-014 run_event  output  1  one-cycle pulse on entry to LOCK.

Function
REQ-015 A sample is accepted in a cycle when in_valid=1 and in_ready=1; all other cycles leave the statistics unchanged.
REQ-016 in_ready is combinational and equals the inverse of clear; a sample presented in a clear cycle is dropped.
REQ-017 The FSM has three states: IDLE (last accepted z=0, or no sample yet), RUN (0 < run_len < THRESH), and LOCK (run_len >= THRESH).
REQ-018 On an accepted z=1, run_len increments, saturating at 2^RUN_W-1, and match_cnt increments, saturating at 2^CNT_W-1.
REQ-019 On an accepted z=1, the state moves IDLE->RUN, or IDLE->LOCK when THRESH=1; RUN->LOCK when the new run_len equals THRESH; LOCK stays LOCK.
REQ-020 On an accepted z=0, run_len clears to 0 and any state goes to IDLE.
REQ-021 max_run updates in the same cycle that run_len does, to max(max_run, new run_len); no extra latency.
REQ-022 run_event is registered; it is high for exactly the cycle after the edge on which the state enters LOCK.
REQ-023 While in LOCK at saturated run_len, run_event does not re-fire; locked stays 1.
REQ-024 All outputs except in_ready are registered; every update is visible one clock after the accepting edge.
REQ-025 clear=1 sets match_cnt, run_len and max_run to 0, the state to IDLE, and run_event to 0 on the next edge, taking priority over in_valid.
REQ-026 No output wraps around; once saturated, match_cnt and run_len hold their maximum values.

Reset
REQ-027 rst_n=0 immediately forces the state to IDLE and sets match_cnt=0, run_len=0, max_run=0, locked=0 and run_event=0, independent of clk.
REQ-028 Reset asserted mid-run discards all statistics; the first accepted sample after release is treated as the start of a fresh stream.
REQ-029 in_ready is 1 during reset whenever clear=0.

Configuration
REQ-030 Macro MATCH_RUN_TRACKER_MISMATCH_CNT_EN, when defined, adds the output port mismatch_cnt (output, CNT_W bits).
REQ-031 With that macro, mismatch_cnt counts accepted z=0 samples, saturates at 2^CNT_W-1, and is reset and cleared like match_cnt.
REQ-032 Without that macro, the mismatch_cnt port and its logic are absent, and all other behaviour is identical.

Verification
REQ-033 Reset then z stream 1,1,1 with in_valid held high (THRESH=3) -> run_len 1,2,3; locked=1 and run_event pulses once after the third sample; match_cnt=3.
REQ-034 Stream 1,1,0,1 -> run_len 1,2,0,1; max_run=2; locked never asserts; match_cnt=3.
REQ-035 16 consecutive z=1 samples (RUN_W=4) -> run_len saturates at 15; max_run=15; exactly one run_event pulse.
REQ-036 clear asserted together with in_valid=1, z=1 during LOCK -> in_ready=0, the sample is dropped, and all counters read 0 with the state in IDLE on the next cycle.
REQ-037 rst_n pulsed low between clock edges mid-run -> outputs read 0 immediately, without waiting for a clock edge; with the macro defined, mismatch_cnt also reads 0.
REQ-038 in_valid=0 for 5 cycles with z toggling -> no statistic changes.
